// File: rtl/rr_packet_arbiter_pkg.sv
// Shared types and index helpers for the round-robin packet arbiter.
package rr_packet_arbiter_pkg;

  // Upper bound on requester count supported by the one-hot helper.
  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Wrapping increment: idx+1 == width rolls back to 0 (valid for any width).
  function automatic int unsigned inc_mod(input int unsigned idx, input int unsigned width);
    return (idx + 1 == width) ? 0 : idx + 1;
  endfunction

  // One-hot decode of an index; callers truncate to their own width.
  function automatic logic [MAX_WIDTH-1:0] onehot(input int unsigned idx);
    return MAX_WIDTH'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_packet_arbiter_search.sv
// Rotating-priority search: first set bit at or above i_ptr, else first set
// bit overall. The vector is zero-padded to a power of SPLIT and reduced by a
// radix-SPLIT find-first tree, run once on the high half and once on all bits.
module rr_search #(
  parameter  int WIDTH     = 8,
  parameter  int SPLIT     = 2,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     i_vec,
  input  logic [WIDTH_LOG-1:0] i_ptr,
  output logic [WIDTH_LOG-1:0] o_idx,
  output logic                 o_vld
);

  function automatic int calc_levels(input int w, input int s);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < w) begin
      p = p * s;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int LEVELS  = calc_levels(WIDTH, SPLIT);
  localparam int PAD_W   = SPLIT ** LEVELS;
  localparam int PAD_LOG = $clog2(PAD_W);

  // Returns {found, index of lowest set bit}. Each level collapses groups of
  // SPLIT nodes in place; node k only reads nodes >= k, so no value is lost.
  function automatic logic [PAD_LOG:0] tree_ffs(input logic [PAD_W-1:0] v);
    logic [PAD_W-1:0]   node_vld;
    logic [PAD_LOG-1:0] node_idx [PAD_W];
    logic               hit;
    logic [PAD_LOG-1:0] sel;
    int                 n;
    node_vld = v;
    for (int i = 0; i < PAD_W; i++) node_idx[i] = PAD_LOG'(i);
    n = PAD_W;
    for (int l = 0; l < LEVELS; l++) begin
      n = n / SPLIT;
      for (int k = 0; k < PAD_W; k++) begin
        if (k < n) begin
          hit = 1'b0;
          sel = '0;
          for (int c = SPLIT - 1; c >= 0; c--) begin
            if (node_vld[k*SPLIT+c]) begin
              hit = 1'b1;
              sel = node_idx[k*SPLIT+c];
            end
          end
          node_vld[k] = hit;
          node_idx[k] = sel;
        end
      end
    end
    return {node_vld[0], node_idx[0]};
  endfunction

  logic [PAD_W-1:0]   w_pad;
  logic [PAD_W-1:0]   w_hi;
  logic [PAD_LOG:0]   w_hi_res;
  logic [PAD_LOG:0]   w_all_res;
  logic [PAD_LOG-1:0] w_sel;

  // Pad, mask the at-or-above-pointer bits, and pick high half before wrap.
  always_comb begin
    w_pad = '0;
    w_pad[WIDTH-1:0] = i_vec;
    w_hi = '0;
    for (int i = 0; i < PAD_W; i++) w_hi[i] = w_pad[i] & (i >= int'(i_ptr));
    w_hi_res  = tree_ffs(w_hi);
    w_all_res = tree_ffs(w_pad);
    w_sel = w_hi_res[PAD_LOG] ? w_hi_res[PAD_LOG-1:0] : w_all_res[PAD_LOG-1:0];
    o_vld = w_all_res[PAD_LOG];
    o_idx = WIDTH_LOG'(w_sel);
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin arbiter with packet locking in front of one valid/ready channel.
// A grant is held until its last beat transfers; handover to the next
// requester in rotating order happens in that same cycle.
module rr_packet_arbiter
  import rr_packet_arbiter_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int SPLIT     = 2,
  parameter  int LOCK      = 1,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req_vld,
  input  logic [WIDTH-1:0]     req_lst,
  output logic [WIDTH-1:0]     req_rdy,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 out_lst,
  output logic [WIDTH_LOG-1:0] out_idx,
  output logic                 gnt_own
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH_LOG-1:0] r_gnt_idx;
  logic [WIDTH_LOG-1:0] r_ptr;
  logic [WIDTH_LOG-1:0] w_gnt_idx_nxt;
  logic [WIDTH_LOG-1:0] w_ptr_nxt;
  logic [WIDTH_LOG-1:0] w_hand_ptr;
  logic [WIDTH-1:0]     w_hand_vec;
  logic [WIDTH_LOG-1:0] w_idle_idx;
  logic [WIDTH_LOG-1:0] w_hand_idx;
  logic                 w_idle_vld;
  logic                 w_hand_vld;

  // The finishing holder is masked out: its req_vld still reflects the beat
  // being completed, so it may only re-win from IDLE a cycle later.
  assign w_hand_ptr = WIDTH_LOG'(inc_mod(32'(r_gnt_idx), WIDTH));
  assign w_hand_vec = req_vld & ~WIDTH'(onehot(32'(r_gnt_idx)));
  assign gnt_own    = (r_state == BUSY);

  rr_search #(.WIDTH(WIDTH), .SPLIT(SPLIT)) u_idle_search (
    .i_vec (req_vld),
    .i_ptr (r_ptr),
    .o_idx (w_idle_idx),
    .o_vld (w_idle_vld)
  );

  rr_search #(.WIDTH(WIDTH), .SPLIT(SPLIT)) u_hand_search (
    .i_vec (w_hand_vec),
    .i_ptr (w_hand_ptr),
    .o_idx (w_hand_idx),
    .o_vld (w_hand_vld)
  );

  // Grant state, holder index and fairness pointer; reset abandons any packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt_idx <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  // Channel outputs from the holder, then next grant/pointer selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_idx_nxt = r_gnt_idx;
    w_ptr_nxt     = r_ptr;
    req_rdy       = '0;
    out_vld       = 1'b0;
    out_lst       = 1'b0;
    out_idx       = '0;
    case (r_state)
      IDLE: begin
        if (w_idle_vld) begin
          w_state_nxt   = BUSY;
          w_gnt_idx_nxt = w_idle_idx;
        end
      end
      BUSY: begin
        out_idx            = r_gnt_idx;
        out_vld            = req_vld[r_gnt_idx];
        out_lst            = (LOCK != 0) ? req_lst[r_gnt_idx] : 1'b1;
        req_rdy[r_gnt_idx] = out_rdy;
        if (out_vld && out_rdy && out_lst) begin
          w_ptr_nxt = w_hand_ptr;
          if (w_hand_vld) begin
            w_gnt_idx_nxt = w_hand_idx;
          end else begin
            w_state_nxt   = IDLE;
            w_gnt_idx_nxt = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter: an 8-requester radix-2 instance and a
// 5-requester radix-4 instance sharing clock and reset.
module tb_rr_packet_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_vld, req_lst, req_rdy;
  logic       out_vld, out_rdy, out_lst, gnt_own;
  logic [2:0] out_idx;

  logic [4:0] v5_req_vld, v5_req_lst, v5_req_rdy;
  logic       v5_out_vld, v5_out_rdy, v5_out_lst, v5_gnt_own;
  logic [2:0] v5_out_idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_packet_arbiter #(.WIDTH(8), .SPLIT(2), .LOCK(1)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_lst (req_lst),
    .req_rdy (req_rdy),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_lst (out_lst),
    .out_idx (out_idx),
    .gnt_own (gnt_own)
  );

  rr_packet_arbiter #(.WIDTH(5), .SPLIT(4), .LOCK(1)) dut5 (
    .clk     (clk),
    .rst     (rst),
    .req_vld (v5_req_vld),
    .req_lst (v5_req_lst),
    .req_rdy (v5_req_rdy),
    .out_vld (v5_out_vld),
    .out_rdy (v5_out_rdy),
    .out_lst (v5_out_lst),
    .out_idx (v5_out_idx),
    .gnt_own (v5_gnt_own)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_vld    = '0;
    req_lst    = '0;
    out_rdy    = 1'b0;
    v5_req_vld = '0;
    v5_req_lst = '0;
    v5_out_rdy = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic       rdy;
    logic [7:0] exp_rdy;
    do_reset();
    rst = 1'b1;
    step();
    #1;
    chk("rst_own",   32'(gnt_own), 32'd0);
    chk("rst_vld",   32'(out_vld), 32'd0);
    chk("rst_lst",   32'(out_lst), 32'd0);
    chk("rst_rdy",   32'(req_rdy), 32'd0);
    chk("rst_idx",   32'(out_idx), 32'd0);
    chk("rst_ptr",   32'(dut8.r_ptr), 32'd0);
    chk("rst_own5",  32'(v5_gnt_own), 32'd0);
    rst = 1'b0;

    // Two requesters alternating single-beat packets with no bubbles.
    req_vld = 8'h81;
    req_lst = 8'hFF;
    out_rdy = 1'b1;
    #1;
    chk("alt_idle_own", 32'(gnt_own), 32'd0);
    chk("alt_idle_vld", 32'(out_vld), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_idx", 32'(out_idx), (i % 2 == 0) ? 32'd0 : 32'd7);
      chk("alt_ptr", 32'(dut8.r_ptr), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("alt_rdy", 32'(req_rdy), (i % 2 == 0) ? 32'h01 : 32'h80);
      chk("alt_own", 32'(gnt_own), 32'd1);
      step();
    end

    // Five requesters, radix-4 tree: order 0..4 then wrap.
    do_reset();
    v5_req_vld = 5'h1F;
    v5_req_lst = 5'h1F;
    v5_out_rdy = 1'b1;
    #1;
    chk("w5_idle_own", 32'(v5_gnt_own), 32'd0);
    step();
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("w5_idx", 32'(v5_out_idx), 32'(i % 5));
      chk("w5_ptr", 32'(dut5.r_ptr), 32'(i % 5));
      chk("w5_vld", 32'(v5_out_vld), 32'd1);
      step();
    end

    // Locked 4-beat packet from 2 with toggling ready; 5 waits, then zero-bubble handover.
    do_reset();
    req_vld = 8'h24;
    req_lst = 8'h20;
    out_rdy = 1'b1;
    #1;
    step();
    for (int c = 0; c < 7; c++) begin
      rdy     = (c % 2 == 0);
      out_rdy = rdy;
      req_lst = (c == 6) ? 8'h24 : 8'h20;
      exp_rdy = rdy ? 8'h04 : 8'h00;
      #1;
      chk("lock_idx", 32'(out_idx), 32'd2);
      chk("lock_rdy", 32'(req_rdy), 32'(exp_rdy));
      chk("lock_lst", 32'(out_lst), (c == 6) ? 32'd1 : 32'd0);
      step();
    end
    out_rdy = 1'b1;
    #1;
    chk("lock_hand_idx", 32'(out_idx), 32'd5);
    chk("lock_hand_rdy", 32'(req_rdy), 32'h20);
    chk("lock_hand_own", 32'(gnt_own), 32'd1);
    chk("lock_hand_ptr", 32'(dut8.r_ptr), 32'd3);

    // Lone requester 3 with two single-beat packets: one IDLE cycle between.
    do_reset();
    req_vld = 8'h08;
    req_lst = 8'h08;
    out_rdy = 1'b1;
    #1;
    chk("solo_own0", 32'(gnt_own), 32'd0);
    step();
    #1;
    chk("solo_own1", 32'(gnt_own), 32'd1);
    chk("solo_idx1", 32'(out_idx), 32'd3);
    chk("solo_rdy1", 32'(req_rdy), 32'h08);
    step();
    #1;
    chk("solo_gap_own", 32'(gnt_own), 32'd0);
    chk("solo_gap_rdy", 32'(req_rdy), 32'h00);
    step();
    #1;
    chk("solo_own2", 32'(gnt_own), 32'd1);
    chk("solo_idx2", 32'(out_idx), 32'd3);

    // Holder 1 stalls mid-packet for 3 cycles; 6 must not be served.
    do_reset();
    req_vld = 8'h42;
    req_lst = 8'h40;
    out_rdy = 1'b1;
    #1;
    step();
    #1;
    chk("stall_first_idx", 32'(out_idx), 32'd1);
    chk("stall_first_vld", 32'(out_vld), 32'd1);
    step();
    req_vld = 8'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_vld", 32'(out_vld), 32'd0);
      chk("stall_idx", 32'(out_idx), 32'd1);
      chk("stall_rdy", 32'(req_rdy), 32'h02);
      step();
    end
    req_vld = 8'h42;
    req_lst = 8'h42;
    #1;
    chk("stall_last_vld", 32'(out_vld), 32'd1);
    chk("stall_last_lst", 32'(out_lst), 32'd1);
    chk("stall_last_rdy", 32'(req_rdy), 32'h02);
    step();
    #1;
    chk("stall_hand_idx", 32'(out_idx), 32'd6);
    chk("stall_hand_rdy", 32'(req_rdy), 32'h40);
    chk("stall_hand_ptr", 32'(dut8.r_ptr), 32'd2);

    // Reset in the middle of requester 6's packet while a beat transfers.
    req_vld = 8'h40;
    req_lst = 8'h00;
    rst     = 1'b1;
    #1;
    step();
    #1;
    chk("mrst_own", 32'(gnt_own), 32'd0);
    chk("mrst_vld", 32'(out_vld), 32'd0);
    chk("mrst_lst", 32'(out_lst), 32'd0);
    chk("mrst_rdy", 32'(req_rdy), 32'd0);
    chk("mrst_idx", 32'(out_idx), 32'd0);
    chk("mrst_ptr", 32'(dut8.r_ptr), 32'd0);
    rst     = 1'b0;
    req_vld = 8'h41;
    req_lst = 8'h41;
    #1;
    step();
    #1;
    chk("mrst_regrant_own", 32'(gnt_own), 32'd1);
    chk("mrst_regrant_idx", 32'(out_idx), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
